// File: rtl/csa_mult_pkg.sv
// Shared sizing helpers for the pipelined carry-save array multiplier.
// The stage record type is declared in csa_mult_pipe using these helpers,
// since its field widths follow the top-level parameters.
package csa_mult_pkg;

  // Number of carry-save pipeline stages (row groups).
  function automatic int unsigned csa_stages(input int unsigned width,
                                             input int unsigned rows_per_stage);
    return width / rows_per_stage;
  endfunction

  // Total register stages from acceptance to result: row groups plus merge.
  function automatic int unsigned csa_latency(input int unsigned width,
                                              input int unsigned rows_per_stage);
    return csa_stages(width, rows_per_stage) + 1;
  endfunction

  // Product width for a WIDTH x WIDTH multiply.
  function automatic int unsigned csa_pw(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/csa_mult_row.sv
// One carry-save row of the array multiplier: folds partial-product row ROW
// (a[j] & b[ROW] placed at bit ROW+j) into a redundant sum/carry pair.
// Baugh-Wooley inversions are applied when i_signed is set; the constant
// injection is done once at the top of the array, not here.
module csa_row
  import csa_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROW   = 0
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic               i_b,
  input  logic [2*WIDTH-1:0] i_sum,
  input  logic [2*WIDTH-1:0] i_carry,
  input  logic               i_signed,
  output logic [2*WIDTH-1:0] o_sum,
  output logic [2*WIDTH-1:0] o_carry
);

  localparam int unsigned PW = csa_pw(WIDTH);

  // Carry generated at bit k, which lands at bit k+1 of o_carry. The carry
  // out of the top bit is outside the product width and is dropped.
  logic [PW-2:0] w_cout;

  for (genvar k = 0; k < PW; k++) begin : g_bit
    if (k >= ROW && k < ROW + WIDTH) begin : g_fa
      localparam int unsigned J = k - ROW;
      // Sign-weighted terms: last column of every row but the last, and every
      // column but the last of the final row.
      localparam bit INV = (J == WIDTH - 1) != (ROW == WIDTH - 1);
      logic w_pp;
      assign w_pp      = (i_a[J] & i_b) ^ (INV & i_signed);
      assign o_sum[k]  = i_sum[k] ^ i_carry[k] ^ w_pp;
      assign w_cout[k] = (i_sum[k] & i_carry[k]) | (i_sum[k] & w_pp) | (i_carry[k] & w_pp);
    end else begin : g_ha
      assign o_sum[k] = i_sum[k] ^ i_carry[k];
      if (k < PW - 1) begin : g_hc
        assign w_cout[k] = i_sum[k] & i_carry[k];
      end
    end
  end

  assign o_carry = {w_cout, 1'b0};

endmodule

// File: rtl/csa_mult_pipe.sv
// Pipelined WIDTH x WIDTH carry-save array multiplier with valid/ready on both
// sides. ROWS_PER_STAGE carry-save rows are evaluated between registers, and a
// final registered adder merges the sum/carry vectors. The whole pipeline
// advances together and freezes while a result is held by the consumer.
// Optional feature macro: CSA_MULT_SIGNED_EN enables per-operation
// two's-complement (Baugh-Wooley) mode via in_signed; without it, in_signed
// is ignored and every operation is unsigned.
module csa_mult_pipe
  import csa_mult_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ROWS_PER_STAGE = 2,
  parameter int unsigned TAG_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned S   = csa_stages(WIDTH, ROWS_PER_STAGE);
  localparam int unsigned PW  = csa_pw(WIDTH);
  localparam int unsigned RPS = ROWS_PER_STAGE;

  if (WIDTH < 4 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_param_check
    $error("csa_mult_pipe: WIDTH must be >= 4 and a multiple of ROWS_PER_STAGE");
  end

  typedef struct packed {
    logic             vld;
`ifdef CSA_MULT_SIGNED_EN
    logic             sgn;
`endif
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  logic             w_en;
  logic             r_out_vld;
  logic [PW-1:0]    r_p;
  logic [TAG_W-1:0] r_tag;
  stage_t           w_in0;
  stage_t           w_q [S];

  assign w_en      = !r_out_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_vld;
  assign out_p     = r_p;
  assign out_tag   = r_tag;

  // Seed record for the first row group. Signed mode preloads the
  // Baugh-Wooley correction constant (bits WIDTH and 2*WIDTH-1) into the sum.
  always_comb begin
    w_in0       = '0;
    w_in0.vld   = in_valid;
    w_in0.tag   = in_tag;
    w_in0.a     = in_a;
    w_in0.b     = in_b;
    w_in0.carry = '0;
`ifdef CSA_MULT_SIGNED_EN
    w_in0.sgn   = in_signed;
    w_in0.sum   = '0;
    if (in_signed) begin
      w_in0.sum[WIDTH]  = 1'b1;
      w_in0.sum[PW-1]   = 1'b1;
    end
`else
    w_in0.sum   = '0;
`endif
  end

  for (genvar g = 0; g < S; g++) begin : g_stage
    stage_t        w_in;
    stage_t        w_nxt;
    stage_t        r_q;
    logic          w_sgn;
    logic [PW-1:0] w_sum [RPS+1];
    logic [PW-1:0] w_car [RPS+1];

    if (g == 0) begin : g_first
      assign w_in = w_in0;
    end else begin : g_chain
      assign w_in = w_q[g-1];
    end

`ifdef CSA_MULT_SIGNED_EN
    assign w_sgn = w_in.sgn;
`else
    assign w_sgn = 1'b0;
`endif

    assign w_sum[0] = w_in.sum;
    assign w_car[0] = w_in.carry;

    for (genvar r = 0; r < RPS; r++) begin : g_row
      csa_row #(
        .WIDTH (WIDTH),
        .ROW   (g * RPS + r)
      ) u_row (
        .i_a      (w_in.a),
        .i_b      (w_in.b[g*RPS+r]),
        .i_sum    (w_sum[r]),
        .i_carry  (w_car[r]),
        .i_signed (w_sgn),
        .o_sum    (w_sum[r+1]),
        .o_carry  (w_car[r+1])
      );
    end

    // Carry the record forward with this group's rows folded in.
    always_comb begin
      w_nxt       = w_in;
      w_nxt.sum   = w_sum[RPS];
      w_nxt.carry = w_car[RPS];
    end

    // Stage register: advances only with the global enable; reset clears valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_q.vld <= 1'b0;
      end else if (w_en) begin
        r_q <= w_nxt;
      end
    end

    assign w_q[g] = r_q;
  end

  // Merge stage: carry-propagate add of the redundant pair into the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_p       <= '0;
      r_tag     <= '0;
    end else if (w_en) begin
      r_out_vld <= w_q[S-1].vld;
      r_p       <= w_q[S-1].sum + w_q[S-1].carry;
      r_tag     <= w_q[S-1].tag;
    end
  end

  // Operands and mode are not needed once the last row group has run.
  logic w_unused;
`ifdef CSA_MULT_SIGNED_EN
  assign w_unused = ^{w_q[S-1].sgn, w_q[S-1].a, w_q[S-1].b};
`else
  assign w_unused = ^{in_signed, w_q[S-1].a, w_q[S-1].b};
`endif

endmodule

// File: tb/tb_csa_mult_pipe.sv
// Self-checking bench for csa_mult_pipe at default parameters. Results are
// compared against an integer-arithmetic model through a scoreboard that also
// tracks acceptance cycle and stall cycles to verify latency and ordering.
module tb_csa_mult_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned R  = 2;
  localparam int unsigned TW = 4;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned L  = W / R + 1;
`ifdef CSA_MULT_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_signed;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  csa_mult_pipe #(
    .WIDTH          (W),
    .ROWS_PER_STAGE (R),
    .TAG_W          (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Exact product of the operands interpreted per mode, truncated to PW bits.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    longint va, vb, pr;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    pr = va * vb;
    return pr[PW-1:0];
  endfunction

  typedef struct {
    logic [PW-1:0] p;
    logic [TW-1:0] tag;
    int unsigned   cyc;
    int unsigned   stl;
  } exp_t;

  exp_t          q[$];
  int unsigned   cyc    = 0;
  int unsigned   stalls = 0;
  logic          was_stall = 1'b0;
  logic [PW-1:0] held_p;
  logic [TW-1:0] held_tag;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record acceptances, match completions, check stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      was_stall = 1'b0;
    end else begin
      if (was_stall) begin
        check("stall_p_stable", out_p, held_p);
        check("stall_tag_stable", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("product", out_p, e.p);
          check("tag", out_tag, e.tag);
          check("latency", cyc - e.cyc, L + (stalls - e.stl));
        end
      end
      was_stall = out_valid && !out_ready;
      if (was_stall) begin
        stalls++;
        held_p   = out_p;
        held_tag = out_tag;
      end
      if (in_valid && in_ready)
        q.push_back('{p: ref_mul(in_a, in_b, in_signed & SGN_EN), tag: in_tag,
                      cyc: cyc, stl: stalls});
    end
  end

  // Present one operation and hold it until accepted; called at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [W-1:0] ca [8] = '{8'h80, 8'hFF, 8'h80, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'hFF};
  logic [W-1:0] cb [8] = '{8'h80, 8'h01, 8'h7F, 8'h80, 8'h01, 8'h7F, 8'h80, 8'hFF};
  logic         cs [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  bit done;
  int unsigned vcount;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Unsigned maximum.
    send(8'hFF, 8'hFF, 1'b0, 4'h5);
    drain();

    // Signed and unsigned corners, back to back.
    for (int i = 0; i < 8; i++) send(ca[i], cb[i], cs[i], TW'(i));
    drain();

    // Sixteen consecutive random operations, tags 0..15.
    for (int i = 0; i < 16; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), TW'(i));
    drain();

    // Backpressure: hold out_ready low for 3 cycles while a result is presented.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(W'($urandom), W'($urandom), 1'($urandom), TW'(i));
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) check("bp_wait_valid", out_valid, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight: three accepted operations must vanish.
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom), TW'(i + 9));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vcount = 0;
    repeat (L + 4) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("rst_flush_no_valid", vcount, 0);
    @(posedge clk);
    #1;
    send(8'h9C, 8'h37, 1'b1, 4'hA);
    drain();

    // Random traffic with random gaps and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom), TW'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
